muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the Hi/Lo register pair and serialises MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO issued from the Execute stage. It runs a shared 32-iteration shift/add-subtract core and produces a stall request back to the pipeline when a new Hi/Lo operation or a Hi/Lo read collides with an operation in flight. HiData/LoData replace the single-cycle Hi/Lo outputs of Execute.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_shift_core.sv | 88 ++++++++
 rtl/muldiv_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and enumerations for the Hi/Lo multiply/divide
// sequencer. The optional divide path is selected by the MULDIV_DIV_EN macro
// in the files that import this package.
package muldiv_pkg;

   localparam int DATA_W = 32;
   localparam int ITER   = 32;
   localparam int CNT_W  = 5;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MSUB  = 3'd5,
      OP_MTHI  = 3'd6,
      OP_MTLO  = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_shift_core.sv
// muldiv_shift_core: 64-bit {hi,lo} shift register with one 33-bit
// adder/subtractor. Multiply mode performs unsigned shift-add (lo holds the
// multiplier), divide mode performs restoring shift-subtract (lo holds the
// dividend and collects quotient bits). The subtract path exists only when
// MULDIV_DIV_EN is defined.
module muldiv_shift_core
   import muldiv_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              load,
   input  logic              step,
   input  logic              divMode,
   input  logic [DATA_W-1:0] loadLo,
   input  logic [DATA_W-1:0] loadOperand,
   output logic [DATA_W-1:0] accHi,
   output logic [DATA_W-1:0] accLo
);

   logic [DATA_W-1:0] hiR;
   logic [DATA_W-1:0] loR;
   logic [DATA_W-1:0] operandR;
   logic [DATA_W:0]   addA;
   logic [DATA_W:0]   addB;
   logic              addCin;
   logic [DATA_W:0]   addSum;
   logic [DATA_W-1:0] nextHi;
   logic [DATA_W-1:0] nextLo;

`ifndef MULDIV_DIV_EN
   logic unusedDivMode;
   assign unusedDivMode = divMode;
`endif

   assign addSum = addA + addB + {{DATA_W{1'b0}}, addCin};

   // Select adder operands and form the next shift-register value for one iteration
   always_comb begin
      addA   = {1'b0, hiR};
      addB   = loR[0] ? {1'b0, operandR} : {(DATA_W+1){1'b0}};
      addCin = 1'b0;
      nextHi = addSum[DATA_W:1];
      nextLo = {addSum[0], loR[DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
      if (divMode) begin
         // Partial remainder shifted left with the next dividend bit, minus divisor.
         // The remainder stays below the divisor, so bit DATA_W of the 33-bit
         // difference is a clean borrow flag.
         addA   = {hiR, loR[DATA_W-1]};
         addB   = ~{1'b0, operandR};
         addCin = 1'b1;
         if (addSum[DATA_W]) begin
            nextHi = {hiR[DATA_W-2:0], loR[DATA_W-1]};
            nextLo = {loR[DATA_W-2:0], 1'b0};
         end else begin
            nextHi = addSum[DATA_W-1:0];
            nextLo = {loR[DATA_W-2:0], 1'b1};
         end
      end else begin
         addA   = {1'b0, hiR};
         addB   = loR[0] ? {1'b0, operandR} : {(DATA_W+1){1'b0}};
         addCin = 1'b0;
         nextHi = addSum[DATA_W:1];
         nextLo = {addSum[0], loR[DATA_W-1:1]};
      end
`endif
   end

   // Shift register and latched operand: load clears hi, step advances one iteration
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         hiR      <= {DATA_W{1'b0}};
         loR      <= {DATA_W{1'b0}};
         operandR <= {DATA_W{1'b0}};
      end else if (load) begin
         hiR      <= {DATA_W{1'b0}};
         loR      <= loadLo;
         operandR <= loadOperand;
      end else if (step) begin
         hiR      <= nextHi;
         loR      <= nextLo;
      end
   end

   assign accHi = hiR;
   assign accLo = loR;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: owns Hi/Lo and serialises MULT/MULTU/DIV/DIVU/MADD/MSUB
// (34-cycle latency) and MTHI/MTLO (1-cycle latency). Requests a pipeline
// stall when a Hi/Lo op or read meets an op in flight.
// Optional divide path: define MULDIV_DIV_EN.
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic [2:0]        Op,
   input  logic [DATA_W-1:0] OperandA,
   input  logic [DATA_W-1:0] OperandB,
   input  logic              ReadHiLo,
   output logic              Stall,
   output logic              Busy,
   output logic              Done,
   output logic              DivByZero,
   output logic [DATA_W-1:0] HiData,
   output logic [DATA_W-1:0] LoData
);

   state_t              state;
   state_t              nextState;
   op_t                 opIn;
   op_t                 opR;
   logic [CNT_W-1:0]    count;
   logic [DATA_W-1:0]   hiR;
   logic [DATA_W-1:0]   loR;
   logic                doneR;
   logic                prodNegR;
   logic                launch;
   logic                coreStep;
   logic                coreDivMode;
   logic                signedOp;
   logic                signA;
   logic                signB;
   logic [DATA_W-1:0]   absA;
   logic [DATA_W-1:0]   absB;
   logic [DATA_W-1:0]   coreHi;
   logic [DATA_W-1:0]   coreLo;
   logic [2*DATA_W-1:0] signedProd;
   logic [2*DATA_W-1:0] fixSum;
`ifdef MULDIV_DIV_EN
   logic                remNegR;
   logic                dbzR;
`endif

   assign opIn = op_t'(Op);

   // Operand magnitudes and signs for the op presented by EX
   always_comb begin
      case (opIn)
         OP_MULT, OP_DIV, OP_MADD, OP_MSUB: signedOp = 1'b1;
         default:                           signedOp = 1'b0;
      endcase
      signA = signedOp & OperandA[DATA_W-1];
      signB = signedOp & OperandB[DATA_W-1];
      absA  = signA ? ({DATA_W{1'b0}} - OperandA) : OperandA;
      absB  = signB ? ({DATA_W{1'b0}} - OperandB) : OperandB;
   end

   // FSM state register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode and core sequencing controls
   always_comb begin
      nextState = state;
      launch    = 1'b0;
      coreStep  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Start) begin
               case (opIn)
                  OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: launch = 1'b1;
`ifdef MULDIV_DIV_EN
                  OP_DIV, OP_DIVU: launch = (OperandB != {DATA_W{1'b0}});
`endif
                  default: launch = 1'b0;
               endcase
            end else begin
               launch = 1'b0;
            end
            nextState = launch ? ST_RUN : ST_IDLE;
         end
         ST_RUN: begin
            coreStep = 1'b1;
            if (count == CNT_W'(ITER - 1)) begin
               nextState = ST_FIX;
            end else begin
               nextState = ST_RUN;
            end
         end
         ST_FIX:  nextState = ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

`ifdef MULDIV_DIV_EN
   assign coreDivMode = (opR == OP_DIV) || (opR == OP_DIVU);
`else
   assign coreDivMode = 1'b0;
`endif

   muldiv_shift_core u_core (
      .Clk         (Clk),
      .Rst         (Rst),
      .load        (launch),
      .step        (coreStep),
      .divMode     (coreDivMode),
      .loadLo      (absA),
      .loadOperand (absB),
      .accHi       (coreHi),
      .accLo       (coreLo)
   );

   // Sign correction and Hi/Lo result selection applied at the FIX edge
   always_comb begin
      signedProd = prodNegR ? ({(2*DATA_W){1'b0}} - {coreHi, coreLo}) : {coreHi, coreLo};
      case (opR)
         OP_MULT, OP_MULTU: fixSum = signedProd;
         OP_MADD:           fixSum = {hiR, loR} + signedProd;
         OP_MSUB:           fixSum = {hiR, loR} - signedProd;
`ifdef MULDIV_DIV_EN
         OP_DIV, OP_DIVU: begin
            // Quotient sign follows signA^signB, remainder sign follows the dividend
            fixSum = {(remNegR  ? ({DATA_W{1'b0}} - coreHi) : coreHi),
                      (prodNegR ? ({DATA_W{1'b0}} - coreLo) : coreLo)};
         end
`endif
         default:           fixSum = {hiR, loR};
      endcase
   end

   // Hi/Lo registers, op/sign latches, iteration counter and completion pulses
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         hiR      <= {DATA_W{1'b0}};
         loR      <= {DATA_W{1'b0}};
         opR      <= OP_MULT;
         prodNegR <= 1'b0;
         count    <= {CNT_W{1'b0}};
         doneR    <= 1'b0;
`ifdef MULDIV_DIV_EN
         remNegR  <= 1'b0;
         dbzR     <= 1'b0;
`endif
      end else begin
         doneR <= 1'b0;
`ifdef MULDIV_DIV_EN
         dbzR  <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  opR      <= opIn;
                  prodNegR <= signA ^ signB;
                  count    <= {CNT_W{1'b0}};
`ifdef MULDIV_DIV_EN
                  remNegR  <= signA;
`endif
               end else if (Start) begin
                  case (opIn)
                     OP_MTHI: begin
                        hiR   <= OperandA;
                        doneR <= 1'b1;
                     end
                     OP_MTLO: begin
                        loR   <= OperandA;
                        doneR <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        // Not launched: zero divisor, or divide path absent
                        doneR <= 1'b1;
`ifdef MULDIV_DIV_EN
                        dbzR  <= 1'b1;
`endif
                     end
                     default: doneR <= 1'b0;
                  endcase
               end
            end
            ST_RUN: begin
               count <= count + CNT_W'(1);
            end
            ST_FIX: begin
               hiR   <= fixSum[2*DATA_W-1:DATA_W];
               loR   <= fixSum[DATA_W-1:0];
               doneR <= 1'b1;
            end
            default: doneR <= 1'b0;
         endcase
      end
   end

   assign Busy   = (state != ST_IDLE);
   assign Stall  = Busy & (Start | ReadHiLo);
   assign Done   = doneR;
   assign HiData = hiR;
   assign LoData = loR;
`ifdef MULDIV_DIV_EN
   assign DivByZero = dbzR;
`else
   assign DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed cases plus randomized ops checked
// against an arithmetic reference model of Hi/Lo.
module tb_muldiv_sequencer;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] OperandA;
   logic [31:0] OperandB;
   logic        ReadHiLo;
   logic        Stall;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] HiData;
   logic [31:0] LoData;

   int          checks;
   int          errors;
   logic [31:0] mHi;
   logic [31:0] mLo;
   int          eLat;
   logic        eDbz;

   muldiv_sequencer dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .Op        (Op),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .ReadHiLo  (ReadHiLo),
      .Stall     (Stall),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero),
      .HiData    (HiData),
      .LoData    (LoData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: new Hi/Lo, expected latency and divide-by-zero flag
   task automatic modelStep(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] acc;
      longint      sp;
      int          sa;
      int          sb;
      acc  = {mHi, mLo};
      sp   = longint'($signed(a)) * longint'($signed(b));
      sa   = $signed(a);
      sb   = $signed(b);
      eLat = 34;
      eDbz = 1'b0;
      case (op)
         3'd0: acc = sp;
         3'd1: acc = {32'd0, a} * {32'd0, b};
         3'd4: acc = acc + sp;
         3'd5: acc = acc - sp;
         3'd6: begin acc[63:32] = a; eLat = 1; end
         3'd7: begin acc[31:0]  = a; eLat = 1; end
`ifdef MULDIV_DIV_EN
         3'd2: begin
            if (b == 32'd0) begin eLat = 1; eDbz = 1'b1; end
            else begin acc[31:0] = sa / sb; acc[63:32] = sa % sb; end
         end
         3'd3: begin
            if (b == 32'd0) begin eLat = 1; eDbz = 1'b1; end
            else begin acc[31:0] = a / b; acc[63:32] = a % b; end
         end
`else
         3'd2, 3'd3: eLat = 1;
`endif
         default: eLat = 34;
      endcase
      mHi = acc[63:32];
      mLo = acc[31:0];
   endtask

   // Issue one op (optionally in the current Done cycle) and check its completion
   task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inDoneCycle, input string name);
      int cyc;
      if (!inDoneCycle) @(negedge Clk);
      Start = 1'b1; Op = op; OperandA = a; OperandB = b;
      #1;
      checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL %s stall_at_issue: got %b want 0", name, Stall); end
      modelStep(op, a, b);
      @(posedge Clk);
      #1 Start = 1'b0;
      cyc = 1;
      @(negedge Clk);
      if (eLat == 34) begin
         checks++;
         if (Busy !== 1'b1) begin errors++; $display("FAIL %s busy_c1: got %b want 1", name, Busy); end
      end
      while (Done !== 1'b1 && cyc < 60) begin
         @(negedge Clk);
         cyc++;
      end
      checks++;
      if (cyc != eLat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, eLat); end
      checks++;
      if (HiData !== mHi) begin errors++; $display("FAIL %s hi: got %h want %h", name, HiData, mHi); end
      checks++;
      if (LoData !== mLo) begin errors++; $display("FAIL %s lo: got %h want %h", name, LoData, mLo); end
      checks++;
      if (DivByZero !== eDbz) begin errors++; $display("FAIL %s dbz: got %b want %b", name, DivByZero, eDbz); end
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL %s busy_done: got %b want 0", name, Busy); end
   endtask

   task automatic test_reset;
      Rst = 1'b0; Start = 1'b0; Op = 3'd0; OperandA = 32'd0; OperandB = 32'd0; ReadHiLo = 1'b0;
      mHi = 32'd0; mLo = 32'd0;
      repeat (2) @(negedge Clk);
      checks++;
      if ({HiData, LoData} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {HiData, LoData}); end
      checks++;
      if ({Busy, Done, DivByZero, Stall} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b want 0000", {Busy, Done, DivByZero, Stall});
      end
      Rst = 1'b1;
   endtask

   task automatic test_mult;
      runOp(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0, "mult_neg");
      checks++;
      if ({HiData, LoData} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_const: got %h want ffffffffffffffeb", {HiData, LoData}); end
      runOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
      checks++;
      if ({HiData, LoData} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_const: got %h want fffffffe00000001", {HiData, LoData}); end
   endtask

   task automatic test_div;
      runOp(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
`ifdef MULDIV_DIV_EN
      checks++;
      if ({HiData, LoData} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_const: got %h want fffffffffffffffd", {HiData, LoData}); end
`endif
      runOp(3'd3, 32'd100, 32'd7, 1'b0, "divu");
`ifdef MULDIV_DIV_EN
      checks++;
      if ({HiData, LoData} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_const: got %h want 000000020000000e", {HiData, LoData}); end
`endif
   endtask

   task automatic test_madd_msub;
      runOp(3'd6, 32'd0, 32'd0, 1'b0, "mthi0");
      runOp(3'd7, 32'd10, 32'd0, 1'b0, "mtlo10");
      runOp(3'd4, 32'd3, 32'd4, 1'b0, "madd");
      checks++;
      if ({HiData, LoData} !== 64'h16) begin errors++; $display("FAIL madd_const: got %h want 16", {HiData, LoData}); end
      runOp(3'd5, 32'h16, 32'd1, 1'b0, "msub_zero");
      checks++;
      if ({HiData, LoData} !== 64'd0) begin errors++; $display("FAIL msub0_const: got %h want 0", {HiData, LoData}); end
      runOp(3'd5, 32'd2, 32'd3, 1'b0, "msub_neg");
      checks++;
      if ({HiData, LoData} !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL msubn_const: got %h want fffffffffffffffa", {HiData, LoData}); end
   endtask

   task automatic test_stall;
      logic [31:0] keepHi;
      @(negedge Clk);
      Start = 1'b1; Op = 3'd0; OperandA = $urandom; OperandB = $urandom;
      modelStep(3'd0, OperandA, OperandB);
      @(posedge Clk);
      #1 Start = 1'b0;
      keepHi = mHi;
      for (int c = 1; c <= 34; c++) begin
         @(negedge Clk);
         ReadHiLo = (c >= 5);
         Start    = (c == 8);
         Op       = 3'd6;
         OperandA = 32'h5A5A5A5A;
         #1;
         checks++;
         if (Stall !== ((c >= 5 && c < 34) || c == 8)) begin
            errors++; $display("FAIL stall_c%0d: got %b want %b", c, Stall, ((c >= 5 && c < 34) || c == 8));
         end
         checks++;
         if (Done !== (c == 34)) begin errors++; $display("FAIL stall_done_c%0d: got %b want %b", c, Done, (c == 34)); end
      end
      Start = 1'b0;
      checks++;
      if (LoData !== mLo) begin errors++; $display("FAIL stall_lo: got %h want %h", LoData, mLo); end
      checks++;
      if (HiData !== keepHi) begin errors++; $display("FAIL stall_hi_ignored_start: got %h want %h", HiData, keepHi); end
      ReadHiLo = 1'b0;
   endtask

   task automatic test_div_by_zero;
      runOp(3'd2, $urandom, 32'd0, 1'b0, "div_zero");
      runOp(3'd3, $urandom, 32'd0, 1'b0, "divu_zero");
   endtask

   task automatic test_back_to_back;
      runOp(3'd0, $urandom, $urandom, 1'b0, "b2b_first");
      runOp(3'd4, $urandom, $urandom, 1'b1, "b2b_madd");
      runOp(3'd7, $urandom, 32'd0, 1'b1, "b2b_mtlo");
      runOp(3'd5, $urandom, $urandom, 1'b1, "b2b_msub");
   endtask

   task automatic test_random;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(7, 0));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(3, 0) == 0) b = 32'($urandom_range(15, 0));
         if ($urandom_range(7, 0) == 0) b = 32'd0;
         if (op == 3'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         runOp(op, a, b, bit'($urandom_range(1, 0)), "random");
      end
   endtask

   task automatic test_reset_mid;
      @(negedge Clk);
      Start = 1'b1; Op = 3'd0; OperandA = $urandom; OperandB = $urandom;
      @(posedge Clk);
      #1 Start = 1'b0;
      repeat (10) @(negedge Clk);
      Rst = 1'b0;
      #1;
      mHi = 32'd0; mLo = 32'd0;
      checks++;
      if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL rstmid_flags: got %b want 00", {Busy, Done}); end
      checks++;
      if ({HiData, LoData} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo: got %h want 0", {HiData, LoData}); end
      @(negedge Clk);
      Rst = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         checks++;
         if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL rstmid_after_c%0d: got %b want 00", c, {Busy, Done}); end
      end
      checks++;
      if ({HiData, LoData} !== 64'd0) begin errors++; $display("FAIL rstmid_final: got %h want 0", {HiData, LoData}); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_mult();
      test_div();
      test_madd_msub();
      test_stall();
      test_div_by_zero();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
